// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundle of every non-clock signal around the data-RAM arbiter: the two
// requester ports (p0 = pipeline load/store unit, p1 = DMA / debug loader),
// the processor halt level, and the single combinational RAM port.
//
// Modports:
//   slave  - arbiter view: takes requests and halt, drives grants, read data
//            and the RAM port, samples ram_read_data.
//   master - environment view: the requesters plus the RAM model.
//
// Signals:
//   pN_req / pN_we / pN_addr / pN_wdata   request side, held until pN_gnt
//   pN_gnt / pN_err                       one-cycle pulses in the access cycle
//   pN_rvalid / pN_rdata                  registered read return
//   halt                                  sticky "processor finished" level
//   ram_address / ram_write_data /
//   ram_mem_op / ram_read_data            single RAM port
//   ram_complete                          RAM dump strobe
//
// Default values are supplied for the shared memory macros when the
// surrounding project has not defined them.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NONE
`define MEM_OP_NONE 2'b00
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'b01
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'b10
`endif
`ifndef DMEMORY_SIZE
`define DMEMORY_SIZE 64
`endif

interface dmem_arbiter_if;
  // Port 0 (load/store unit)
  logic                     p0_req;
  logic                     p0_we;
  logic [`DATA_WIDTH-1:0]   p0_addr;
  logic [`DATA_WIDTH-1:0]   p0_wdata;
  logic                     p0_gnt;
  logic                     p0_rvalid;
  logic [`DATA_WIDTH-1:0]   p0_rdata;
  logic                     p0_err;
  // Port 1 (secondary master)
  logic                     p1_req;
  logic                     p1_we;
  logic [`DATA_WIDTH-1:0]   p1_addr;
  logic [`DATA_WIDTH-1:0]   p1_wdata;
  logic                     p1_gnt;
  logic                     p1_rvalid;
  logic [`DATA_WIDTH-1:0]   p1_rdata;
  logic                     p1_err;
  // Processor status
  logic                     halt;
  // RAM port
  logic [`DATA_WIDTH-1:0]   ram_address;
  logic [`DATA_WIDTH-1:0]   ram_write_data;
  logic [`MEM_OP_BITS-1:0]  ram_mem_op;
  logic [`DATA_WIDTH-1:0]   ram_read_data;
  logic                     ram_complete;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  halt,
    output ram_address, ram_write_data, ram_mem_op, ram_complete,
    input  ram_read_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output halt,
    input  ram_address, ram_write_data, ram_mem_op, ram_complete,
    output ram_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single combinational data-RAM port between two masters. Each
// access is serialised through IDLE -> ACCESS -> IDLE, so the peak rate is one
// access every two cycles. Read data is registered per port and returned with
// a one-cycle rvalid pulse the cycle after the grant. Once the processor halts
// the arbiter stops granting, spends one DRAIN cycle, then parks in DONE with
// ram_complete held high until reset.
//
// Ports:
//   clk      - clock, all state on the rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - dmem_arbiter_if.slave (requesters, halt, RAM port)
//
// Parameters:
//   MEM_DEPTH - number of valid RAM words; addresses >= MEM_DEPTH are rejected
//               with err, never reach the RAM, and reads return zero.
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//               (the port not granted last wins). When undefined, port 0 has
//               fixed priority and port 1 may starve.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NONE
`define MEM_OP_NONE 2'b00
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'b01
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'b10
`endif
`ifndef DMEMORY_SIZE
`define DMEMORY_SIZE 64
`endif

module dmem_arbiter #(
  parameter int MEM_DEPTH = `DMEMORY_SIZE
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  localparam int DW  = `DATA_WIDTH;
  localparam int OPW = `MEM_OP_BITS;
  localparam logic [DW-1:0] LP_DEPTH = DW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  // Access latched in IDLE and replayed to the RAM during ACCESS.
  logic            r_port;      // 0 = port 0 won, 1 = port 1 won
  logic            r_we;
  logic            r_oor;       // address out of range
  logic [DW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  // Per-port read return.
  logic [DW-1:0]   r_p0_rdata;
  logic [DW-1:0]   r_p1_rdata;
  logic            r_p0_rvalid;
  logic            r_p1_rvalid;

  logic            w_any_req;
  logic            w_pick1;
  logic            w_capture;
  logic            w_sel_we;
  logic [DW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [DW-1:0]   w_rd_value;
  logic [OPW-1:0]  w_mem_op;
  logic            w_p0_gnt;
  logic            w_p1_gnt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_any_req = bus.p0_req | bus.p1_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Last-granted port; resets to port 1 so port 0 takes the first tie.
  logic r_last;
  // Port 1 wins when alone, or on a tie when port 0 was granted last.
  assign w_pick1 = bus.p1_req & (~bus.p0_req | ~r_last);
`else
  assign w_pick1 = bus.p1_req & ~bus.p0_req;
`endif

  assign w_sel_we    = w_pick1 ? bus.p1_we    : bus.p0_we;
  assign w_sel_addr  = w_pick1 ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_pick1 ? bus.p1_wdata : bus.p0_wdata;

  // Out-of-range reads return zero instead of whatever the RAM presents.
  assign w_rd_value = r_oor ? '0 : bus.ram_read_data;

  // ---------------------------------------------------------------------------
  // Next state and RAM-side outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default before the case statement so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_mem_op     = `MEM_OP_NONE;
    w_p0_gnt     = 1'b0;
    w_p1_gnt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // halt beats any pending request; that request is never granted.
        if (bus.halt) begin
          w_next_state = ST_DRAIN;
        end else if (w_any_req) begin
          w_capture    = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_p0_gnt     = ~r_port;
        w_p1_gnt     = r_port;
        if (!r_oor) begin
          w_mem_op = r_we ? `MEM_OP_WRITE : `MEM_OP_READ;
        end
        w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_DONE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_state     <= w_next_state;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;

      if (w_capture) begin
        r_port  <= w_pick1;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_oor   <= (w_sel_addr >= LP_DEPTH);
      end

      if (r_state == ST_ACCESS) begin
        // Capture the combinational RAM result at the end of the access cycle.
        if (!r_we) begin
          if (r_port) begin
            r_p1_rdata  <= w_rd_value;
            r_p1_rvalid <= 1'b1;
          end else begin
            r_p0_rdata  <= w_rd_value;
            r_p0_rvalid <= 1'b1;
          end
        end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // Pointer moves only when a grant actually happens.
        r_last <= r_port;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.p0_gnt    = w_p0_gnt;
  assign bus.p1_gnt    = w_p1_gnt;
  assign bus.p0_err    = w_p0_gnt & r_oor;
  assign bus.p1_err    = w_p1_gnt & r_oor;
  assign bus.p0_rvalid = r_p0_rvalid;
  assign bus.p1_rvalid = r_p1_rvalid;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;

  assign bus.ram_mem_op     = w_mem_op;
  assign bus.ram_address    = r_addr;
  assign bus.ram_write_data = r_wdata;
  assign bus.ram_complete   = (r_state == ST_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed and randomized checks of dmem_arbiter. The bench owns a RAM model
// driven by the arbiter's RAM port, and a separate transaction-level reference
// memory that is updated only from the accesses the bench issues. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NONE
`define MEM_OP_NONE 2'b00
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'b01
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'b10
`endif
`ifndef DMEMORY_SIZE
`define DMEMORY_SIZE 64
`endif

module tb_dmem_arbiter;

  localparam int DEPTH = `DMEMORY_SIZE;
  localparam int DW    = `DATA_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset_n;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Environment RAM and transaction-level reference memory.
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rdata [2];
  logic          ram_loaded   = 1'b0;
  int            n_checks     = 0;
  int            n_fail       = 0;
  int            n_ram_writes = 0;
  int            n_stray      = 0;
  int            exp_writes   = 0;
  int            model_last   = 1;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A);
  endfunction

  assign bus.ram_read_data = (bus.ram_address < DW'(DEPTH)) ?
                             ram[bus.ram_address[AW-1:0]] : '0;

  // RAM write port plus a monitor for RAM activity outside a granted access.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (bus.ram_mem_op == `MEM_OP_WRITE) begin
      if (bus.ram_address < DW'(DEPTH)) begin
        ram[bus.ram_address[AW-1:0]] <= bus.ram_write_data;
        n_ram_writes <= n_ram_writes + 1;
      end else begin
        n_stray <= n_stray + 1;
      end
    end
    if (bus.ram_mem_op != `MEM_OP_NONE && !(bus.p0_gnt || bus.p1_gnt))
      n_stray <= n_stray + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.p0_err : bus.p1_err;
  endfunction
  function automatic logic rvalid_of(input int p);
    return (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
  endfunction
  function automatic logic [DW-1:0] rdata_of(input int p);
    return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  // Expected tie winner from the arbitration rule.
  function automatic int tie_winner();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    return (model_last == 1) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p0_gnt"},    bus.p0_gnt, 0);
    check({tag, "_p1_gnt"},    bus.p1_gnt, 0);
    check({tag, "_p0_rvalid"}, bus.p0_rvalid, 0);
    check({tag, "_p1_rvalid"}, bus.p1_rvalid, 0);
    check({tag, "_p0_err"},    bus.p0_err, 0);
    check({tag, "_p1_err"},    bus.p1_err, 0);
    check({tag, "_p0_rdata"},  bus.p0_rdata, 0);
    check({tag, "_p1_rdata"},  bus.p1_rdata, 0);
    check({tag, "_mem_op"},    bus.ram_mem_op, `MEM_OP_NONE);
    check({tag, "_ram_addr"},  bus.ram_address, 0);
    check({tag, "_ram_wdata"}, bus.ram_write_data, 0);
    check({tag, "_complete"},  bus.ram_complete, 0);
  endtask

  // Single access from port p; starts and ends on a falling edge with the
  // arbiter idle. Checks grant latency, RAM drive, err, rvalid and rdata.
  task automatic do_access(input int p, input logic we,
                           input logic [DW-1:0] addr, input logic [DW-1:0] wdata);
    int   q;
    logic oor;
    q   = 1 - p;
    oor = (addr >= DW'(DEPTH));
    drive(p, 1'b1, we, addr, wdata);
    @(negedge clk);
    check($sformatf("p%0d_gnt", p), gnt_of(p), 1);
    check($sformatf("p%0d_gnt_other", q), gnt_of(q), 0);
    check($sformatf("p%0d_err", p), err_of(p), oor);
    check($sformatf("p%0d_err_other", q), err_of(q), 0);
    check($sformatf("p%0d_mem_op", p), bus.ram_mem_op,
          oor ? `MEM_OP_NONE : (we ? `MEM_OP_WRITE : `MEM_OP_READ));
    if (!oor) begin
      check($sformatf("p%0d_ram_addr", p), bus.ram_address, addr);
      if (we) check($sformatf("p%0d_ram_wdata", p), bus.ram_write_data, wdata);
    end
    drive(p, 1'b0, 1'b0, '0, '0);
    model_last = p;
    if (we && !oor) begin
      ref_mem[addr[AW-1:0]] = wdata;
      exp_writes++;
    end
    @(negedge clk);
    if (!we) exp_rdata[p] = oor ? '0 : ref_mem[addr[AW-1:0]];
    check($sformatf("p%0d_rvalid", p), rvalid_of(p), !we);
    check($sformatf("p%0d_rvalid_other", q), rvalid_of(q), 0);
    check($sformatf("p%0d_gnt_after", p), gnt_of(p), 0);
    check($sformatf("p%0d_rdata", p), rdata_of(p), exp_rdata[p]);
    check($sformatf("p%0d_rdata_other", q), rdata_of(q), exp_rdata[q]);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_last = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    #1;
    check_reset_outputs("rst_pulse");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int arb_addr [2];
    int w;
    int diff_cnt;

    reset_n  = 1'b0;
    bus.halt = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;

    // Reset values.
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Port 0 write then read back.
    do_access(0, 1'b1, DW'(3), DW'(32'hDEAD_BEEF));
    do_access(0, 1'b0, DW'(3), '0);
    check("directed_p0_rdata", bus.p0_rdata, DW'(32'hDEAD_BEEF));
    check("directed_p1_rdata_idle", bus.p1_rdata, 0);

    // Both ports hold reads; first grant after reset goes to port 0.
    pulse_reset();
    arb_addr[0] = 5;
    arb_addr[1] = 9;
    drive(0, 1'b1, 1'b0, DW'(arb_addr[0]), '0);
    drive(1, 1'b1, 1'b0, DW'(arb_addr[1]), '0);
    for (int g = 0; g < 6; g++) begin
      w = tie_winner();
      @(negedge clk);
      check($sformatf("arb%0d_p0_gnt", g), bus.p0_gnt, (w == 0));
      check($sformatf("arb%0d_p1_gnt", g), bus.p1_gnt, (w == 1));
      model_last = w;
      if (g == 5) begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      exp_rdata[w] = ref_mem[arb_addr[w]];
      check($sformatf("arb%0d_rvalid", g), rvalid_of(w), 1);
      check($sformatf("arb%0d_rdata", g), rdata_of(w), exp_rdata[w]);
    end

    // Out-of-range write and read on port 1.
    do_access(1, 1'b1, DW'(DEPTH), DW'(32'h1234_5678));
    do_access(1, 1'b0, DW'(DEPTH + 5), '0);

    // Randomized single accesses, including out-of-range addresses.
    for (int i = 0; i < 40; i++) begin
      do_access(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                DW'($urandom_range(DEPTH + 3, 0)), DW'($urandom));
      if ($urandom_range(3, 0) == 0) @(negedge clk);
    end

    // Reset dropped during a read ACCESS.
    drive(0, 1'b1, 1'b0, DW'(7), '0);
    @(negedge clk);
    check("rst_mid_gnt", bus.p0_gnt, 1);
    drive(0, 1'b0, 1'b0, '0, '0);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_mid_no_rvalid0_%0d", i), bus.p0_rvalid, 0);
      check($sformatf("rst_mid_no_rvalid1_%0d", i), bus.p1_rvalid, 0);
      @(negedge clk);
    end
    do_access(0, 1'b0, DW'(7), '0);

    // halt during a port 0 read ACCESS.
    drive(0, 1'b1, 1'b0, DW'(11), '0);
    @(negedge clk);
    check("halt_gnt", bus.p0_gnt, 1);
    drive(0, 1'b0, 1'b0, '0, '0);
    bus.halt = 1'b1;
    @(negedge clk);
    exp_rdata[0] = ref_mem[11];
    check("halt_rvalid", bus.p0_rvalid, 1);
    check("halt_rdata", bus.p0_rdata, exp_rdata[0]);
    check("halt_complete_early", bus.ram_complete, 0);
    @(negedge clk);
    check("drain_mem_op", bus.ram_mem_op, `MEM_OP_NONE);
    check("drain_complete", bus.ram_complete, 0);
    @(negedge clk);
    check("done_complete", bus.ram_complete, 1);
    drive(1, 1'b1, 1'b1, DW'(2), DW'(32'hCAFE_F00D));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("done_no_gnt_%0d", i), bus.p1_gnt, 0);
      check($sformatf("done_no_rvalid_%0d", i), bus.p1_rvalid, 0);
      check($sformatf("done_mem_op_%0d", i), bus.ram_mem_op, `MEM_OP_NONE);
      check($sformatf("done_complete_%0d", i), bus.ram_complete, 1);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // RAM-side bookkeeping.
    check("stray_ram_ops", n_stray, 0);
    check("ram_write_count", n_ram_writes, exp_writes);
    diff_cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) diff_cnt++;
    check("ram_contents", diff_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the data RAM. It shares the single combinational RAM port between the pipeline load/store unit (port 0) and a secondary master such as a DMA or debug loader (port 1). It serialises accesses through a small FSM and registers read data. When the processor halts, it drains outstanding traffic and only then raises the RAM's `complete` dump strobe.

## Interface
Parameters:
- `MEM_DEPTH`, default `` `DMEMORY_SIZE ``: number of valid RAM words; addresses `>= MEM_DEPTH` are out of range.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `p0_req` / `p1_req`, input, 1: access request; held until `pN_gnt`.
- `p0_we` / `p1_we`, input, 1: 1 = write, 0 = read; stable while `req` is high.
- `p0_addr` / `p1_addr`, input, `DATA_WIDTH`: word address; stable while `req` is high.
- `p0_wdata` / `p1_wdata`, input, `DATA_WIDTH`: write data; stable while `req` is high.
- `p0_gnt` / `p1_gnt`, output, 1: one-cycle pulse; the request is accepted this cycle.
- `p0_rvalid` / `p1_rvalid`, output, 1: one-cycle pulse; `pN_rdata` is valid.
- `p0_rdata` / `p1_rdata`, output, `DATA_WIDTH`: registered read data; holds its value until the next read on that port.
- `p0_err` / `p1_err`, output, 1: pulses together with `gnt` on an out-of-range access.
- `halt`, input, 1: processor finished; level, sticky until reset.
- `ram_address`, `ram_write_data`, output, `DATA_WIDTH`: drive the RAM.
- `ram_mem_op`, output, `MEM_OP_BITS`: `` `MEM_OP_READ ``, `` `MEM_OP_WRITE `` or `` `MEM_OP_NONE ``.
- `ram_read_data`, input, `DATA_WIDTH`: combinational RAM read result.
- `ram_complete`, output, 1: dump strobe to the RAM.

## Operation
- FSM states: IDLE, ACCESS, DRAIN, DONE.
- **IDLE**
  - If `halt` is high, go to DRAIN; no new grants are issued.
  - Otherwise, if any `req` is high, select a winner, register its addr/wdata/we and port id, and go to ACCESS.
- **ACCESS**
  - Lasts exactly one cycle.
  - `ram_mem_op`/`ram_address`/`ram_write_data` are driven from the registered values. The winner's `gnt` pulses.
  - On a read, `ram_read_data` is captured into the winner's `rdata` at the end of the cycle.
  - Returns to IDLE.
- **DRAIN**
  - Lasts one cycle; `ram_mem_op = ` `` `MEM_OP_NONE ``.
  - Goes to DONE.
- **DONE**
  - `ram_complete` is held high; stays in DONE until reset.
  - Requests are ignored: no `gnt`, no `rvalid`.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: winner is chosen per Configuration.
  - The last-granted pointer updates only on a grant.
- Out-of-range (`addr >= MEM_DEPTH`):
  - `ram_mem_op` stays `` `MEM_OP_NONE `` in ACCESS.
  - `gnt` and `err` pulse.
  - A read also returns `rdata = 0` with `rvalid`.
  - A write is dropped.
- In every state other than ACCESS, `ram_mem_op = ` `` `MEM_OP_NONE ``. The RAM is never written outside ACCESS.

## Timing
- Reset values (asynchronous, `reset_n = 0`):
  - FSM = IDLE.
  - All `gnt`/`rvalid`/`err` = 0; all `rdata` = 0.
  - `ram_mem_op = ` `` `MEM_OP_NONE ``; `ram_address` = 0; `ram_write_data` = 0; `ram_complete` = 0.
  - Last-granted pointer = port 1, so port 0 wins the first tie.
- Request seen in IDLE at cycle N → ACCESS and `gnt` in cycle N+1 → `rvalid` (reads only) in cycle N+2.
- Peak throughput: one access per 2 cycles. A port held in `req` after `gnt` is treated as a new request.
- `halt` rising while in ACCESS: the access completes normally (including `rvalid`), then IDLE → DRAIN.
- `halt` and `req` high together in IDLE: `halt` wins; the request is never granted.
- `halt` seen in IDLE at cycle N → DRAIN at N+1 → `ram_complete` high from N+2.
- Reset asserted during ACCESS: the access is abandoned, no `rvalid` follows, and a write in flight may or may not have landed.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN`
  - Defined: simultaneous requests alternate. The port not granted last wins.
  - Undefined: fixed priority; port 0 always wins ties and port 1 can starve.
  - The last-granted pointer is unused and need not be implemented.
- All other behaviour is identical with or without the macro.

## Test plan
- Port 0 writes `addr=3`, `data=0xDEADBEEF`, then reads `addr=3` → `gnt` at N+1, `rvalid` at N+2 with `p0_rdata = 0xDEADBEEF`; port 1 outputs stay 0.
- Both ports hold read requests for 6 cycles with round-robin defined → grants alternate 0,1,0,1…, first grant to port 0. Without the macro → port 0 takes every grant.
- Port 1 writes `addr = MEM_DEPTH` → `p1_gnt` and `p1_err` pulse, `ram_mem_op` stays NONE. A following read at `MEM_DEPTH+5` → `rvalid`, `rdata = 0`, `err` = 1.
- `halt` asserted during a port 0 read ACCESS → `p0_rvalid` still pulses, DRAIN follows, then `ram_complete = 1` and stays high. A later `p1_req` gets no `gnt`.
- Drop `reset_n` mid-ACCESS for one cycle → all outputs return to reset values immediately, no `rvalid` afterwards, and the FSM restarts from IDLE.
